mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the instruction-fetch stage and the load/store (memory) stage of the 4-stage pipeline.
- Arbitrates between the two requesters and drives a req/ack handshake toward a variable-latency memory.
- Returns the read data to the requester it served and produces the stall signals the pipeline uses to freeze its stages.
- The data side consumes the decoder's MemoryRE, MemoryWE, SizeOut and Unsigned outputs unchanged.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter in front of one single-ported memory.
// Drives a req/ack handshake and returns registered data plus stalls.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  FetchReq,
    input  logic [ADDR_WIDTH-1:0] FetchAddr,
    output logic                  FetchValid,
    output logic [DATA_WIDTH-1:0] FetchData,
    input  logic                  DataRE,
    input  logic                  DataWE,
    input  logic [ADDR_WIDTH-1:0] DataAddr,
    input  logic [DATA_WIDTH-1:0] DataWriteData,
    input  logic [1:0]            DataSize,
    input  logic                  DataUnsigned,
    output logic                  DataValid,
    output logic [DATA_WIDTH-1:0] DataReadData,
    output logic                  StallFetch,
    output logic                  StallData,
    output logic                  MemReq,
    output logic                  MemWE,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic [1:0]            MemSize,
    output logic                  MemUnsigned,
    input  logic                  MemAck,
    input  logic [DATA_WIDTH-1:0] MemReadData,
    output logic                  Error
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_F,
        BUSY_D,
        RESP_F,
        RESP_D
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
    logic [DATA_WIDTH-1:0] ddata_q, ddata_d;
    logic                  error_q, error_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic data_req;
    logic fetch_forced;
    logic tmo_hit;

    // Request decode and timeout terminal count.
    always_comb begin
        data_req     = DataRE | DataWE;
        fetch_forced = FetchReq && (streak_q == SW'(MAX_DATA_STREAK));
        tmo_hit      = (TIMEOUT > 0) &&
                       (32'(tmo_q) == 32'(TIMEOUT - 1));
    end

    // Next-state, arbitration, capture and counter update.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        uns_d    = uns_q;
        fdata_d  = fdata_q;
        ddata_d  = ddata_q;
        error_d  = error_q;
        streak_d = streak_q;
        tmo_d    = '0;
        case (state_q)
            IDLE: begin
                if (data_req && !fetch_forced) begin
                    state_d = BUSY_D;
                    we_d    = DataWE;
                    addr_d  = DataAddr;
                    wdata_d = DataWriteData;
                    size_d  = DataSize;
                    uns_d   = DataUnsigned;
                    if (!FetchReq) begin
                        streak_d = '0;
                    end else if (streak_q != SW'(MAX_DATA_STREAK)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (FetchReq) begin
                    state_d  = BUSY_F;
                    we_d     = 1'b0;
                    addr_d   = FetchAddr;
                    size_d   = 2'b11;
                    uns_d    = 1'b0;
                    streak_d = '0;
                end
            end
            BUSY_F, BUSY_D: begin
                if (MemAck) begin
                    state_d = (state_q == BUSY_F) ? RESP_F : RESP_D;
                    if (state_q == BUSY_F) begin
                        fdata_d = MemReadData;
                    end else if (!we_q) begin
                        ddata_d = MemReadData;
                    end
                end else if (tmo_hit) begin
                    state_d = (state_q == BUSY_F) ? RESP_F : RESP_D;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP_F, RESP_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            fdata_q  <= '0;
            ddata_q  <= '0;
            error_q  <= 1'b0;
            streak_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            fdata_q  <= fdata_d;
            ddata_q  <= ddata_d;
            error_q  <= error_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
        end
    end

    // Outputs decoded from state and registers; stalls follow requests.
    always_comb begin
        MemReq       = (state_q == BUSY_F) || (state_q == BUSY_D);
        FetchValid   = (state_q == RESP_F);
        DataValid    = (state_q == RESP_D);
        MemWE        = we_q;
        MemAddr      = addr_q;
        MemWriteData = wdata_q;
        MemSize      = size_q;
        MemUnsigned  = uns_q;
        FetchData    = fdata_q;
        DataReadData = ddata_q;
        Error        = error_q;
        StallFetch   = FetchReq & ~FetchValid;
        StallData    = (DataRE | DataWE) & ~DataValid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a wait-state memory model.
// Table vectors for single accesses, hand sequences for multi-cycle cases.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        Reset;
    logic        FetchReq;
    logic [31:0] FetchAddr;
    logic        FetchValid;
    logic [31:0] FetchData;
    logic        DataRE, DataWE;
    logic [31:0] DataAddr, DataWriteData;
    logic [1:0]  DataSize;
    logic        DataUnsigned;
    logic        DataValid;
    logic [31:0] DataReadData;
    logic        StallFetch, StallData;
    logic        MemReq, MemWE;
    logic [31:0] MemAddr, MemWriteData;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic        MemAck;
    logic [31:0] MemReadData;
    logic        Error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .MAX_DATA_STREAK(4), .TIMEOUT(8)
    ) dut (
        .Clock(clk), .Reset(Reset),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr),
        .FetchValid(FetchValid), .FetchData(FetchData),
        .DataRE(DataRE), .DataWE(DataWE), .DataAddr(DataAddr),
        .DataWriteData(DataWriteData), .DataSize(DataSize),
        .DataUnsigned(DataUnsigned), .DataValid(DataValid),
        .DataReadData(DataReadData),
        .StallFetch(StallFetch), .StallData(StallData),
        .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr),
        .MemWriteData(MemWriteData), .MemSize(MemSize),
        .MemUnsigned(MemUnsigned), .MemAck(MemAck),
        .MemReadData(MemReadData), .Error(Error)
    );

    // Memory model: ack after mem_wait extra cycles of MemReq.
    int          mem_wait = 0;
    bit          no_ack   = 0;
    logic [31:0] rd_val   = '0;
    int          req_cnt  = 0;
    int          req_len  = 0;
    bit          unstable = 0;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [1:0]  cap_size;
    logic        cap_uns;

    always @(negedge clk) begin
        if (MemReq) req_cnt++;
        else req_cnt = 0;
        if (MemReq && req_cnt == 1) begin
            cap_we    = MemWE;
            cap_addr  = MemAddr;
            cap_wdata = MemWriteData;
            cap_size  = MemSize;
            cap_uns   = MemUnsigned;
            unstable  = 0;
        end else if (MemReq && (MemAddr !== cap_addr ||
                     MemWriteData !== cap_wdata || MemWE !== cap_we ||
                     MemSize !== cap_size || MemUnsigned !== cap_uns)) begin
            unstable = 1;
        end
        if (MemReq) req_len = req_cnt;
        MemAck      = MemReq && !no_ack && (req_cnt > mem_wait);
        MemReadData = MemAck ? rd_val : 32'hBAD0_BAD0;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        FetchReq      = 0;
        FetchAddr     = '0;
        DataRE        = 0;
        DataWE        = 0;
        DataAddr      = '0;
        DataWriteData = '0;
        DataSize      = 2'b00;
        DataUnsigned  = 0;
    endtask

    typedef struct {
        logic        is_f;
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        int          wait_n;
        logic        exp_we;
        logic [1:0]  exp_size;
        logic        exp_uns;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        bit got;
        string p;
        p = $sformatf("v%0d_", idx);
        FetchReq      = v.is_f;
        FetchAddr     = v.is_f ? v.addr : 32'h0;
        DataRE        = v.re;
        DataWE        = v.we;
        DataAddr      = v.is_f ? 32'h0 : v.addr;
        DataWriteData = v.wdata;
        DataSize      = v.size;
        DataUnsigned  = v.uns;
        mem_wait      = v.wait_n;
        rd_val        = v.rdata;
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (FetchValid || DataValid) got = 1;
        end
        check({p, "valid_seen"}, 32'(got), 32'd1);
        check({p, "fetch_valid"}, 32'(FetchValid), 32'(v.is_f));
        check({p, "data_valid"}, 32'(DataValid), 32'(!v.is_f));
        check({p, "latency"}, n, v.wait_n + 2);
        check({p, "req_len"}, req_len, v.wait_n + 1);
        check({p, "mem_we"}, 32'(cap_we), 32'(v.exp_we));
        check({p, "mem_size"}, 32'(cap_size), 32'(v.exp_size));
        check({p, "mem_uns"}, 32'(cap_uns), 32'(v.exp_uns));
        check({p, "mem_addr"}, cap_addr, v.addr);
        if (v.exp_we) check({p, "mem_wdata"}, cap_wdata, v.wdata);
        check({p, "result"}, v.is_f ? FetchData : DataReadData,
              v.exp_data);
        check({p, "stable"}, 32'(unstable), 32'd0);
        check({p, "stall_clear"},
              32'(v.is_f ? StallFetch : StallData), 32'd0);
        idle_inputs();
        tick();
    endtask

    initial begin
        int  n;
        bit  stall_ok;
        logic [5:0] order;
        int  cnt;

        Reset = 1;
        idle_inputs();
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 2'b00, 1'b1,
                    32'h2008_0005, 1, 1'b0, 2'b11, 1'b0, 32'h2008_0005};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'b00, 1'b1,
                    32'h0000_00AB, 0, 1'b0, 2'b00, 1'b1, 32'h0000_00AB};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 2'b11,
                    1'b0, 32'h1111_1111, 3, 1'b1, 2'b11, 1'b0,
                    32'h0000_00AB};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0204, 32'h1234_5678, 2'b01,
                    1'b0, 32'h0000_FFFF, 0, 1'b1, 2'b01, 1'b0,
                    32'h0000_00AB};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 2'b01, 1'b0,
                    32'h0000_0013, 0, 1'b0, 2'b11, 1'b0, 32'h0000_0013};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 2'b01, 1'b0,
                    32'hFFFF_8001, 2, 1'b0, 2'b01, 1'b0, 32'hFFFF_8001};

        tick();
        tick();
        check("rst_memreq", 32'(MemReq), 32'd0);
        check("rst_fvalid", 32'(FetchValid), 32'd0);
        check("rst_dvalid", 32'(DataValid), 32'd0);
        check("rst_fdata", FetchData, 32'd0);
        check("rst_ddata", DataReadData, 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        check("rst_memaddr", MemAddr, 32'd0);
        check("rst_memwe", 32'(MemWE), 32'd0);
        Reset = 0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Simultaneous fetch and load: data first, fetch afterwards.
        FetchReq     = 1;
        FetchAddr    = 32'h48;
        DataRE       = 1;
        DataAddr     = 32'h100;
        DataSize     = 2'b00;
        DataUnsigned = 1;
        mem_wait     = 0;
        rd_val       = 32'h77;
        stall_ok     = 1;
        n = 0;
        while (!(FetchValid || DataValid) && n < 40) begin
            tick();
            n++;
            if (!FetchValid && StallFetch !== 1'b1) stall_ok = 0;
        end
        check("both_first_data", 32'(DataValid), 32'd1);
        check("both_first_nofetch", 32'(FetchValid), 32'd0);
        check("both_d_size", 32'(cap_size), 32'd0);
        check("both_d_uns", 32'(cap_uns), 32'd1);
        check("both_d_addr", cap_addr, 32'h100);
        check("both_d_data", DataReadData, 32'h77);
        DataRE = 0;
        rd_val = 32'h88;
        n = 0;
        while (!FetchValid && n < 40) begin
            tick();
            n++;
            if (!FetchValid && StallFetch !== 1'b1) stall_ok = 0;
        end
        check("both_fetch_valid", 32'(FetchValid), 32'd1);
        check("both_f_addr", cap_addr, 32'h48);
        check("both_f_size", 32'(cap_size), 32'd3);
        check("both_f_data", FetchData, 32'h88);
        check("both_stall_held", 32'(stall_ok), 32'd1);
        check("both_stall_clear", 32'(StallFetch), 32'd0);
        idle_inputs();
        tick();

        // Streak limit: D,D,D,D,F,D at one access per 3 cycles.
        FetchReq  = 1;
        FetchAddr = 32'h50;
        DataRE    = 1;
        DataAddr  = 32'h180;
        DataSize  = 2'b11;
        rd_val    = 32'h5555_AAAA;
        order = '0;
        cnt = 0;
        n = 0;
        while (cnt < 6 && n < 60) begin
            tick();
            n++;
            if (FetchValid || DataValid) begin
                order[cnt] = DataValid;
                cnt++;
            end
        end
        check("streak_count", cnt, 6);
        check("streak_order", 32'(order), 32'(6'b101111));
        check("streak_cycles", n, 17);
        idle_inputs();
        tick();

        // Timeout: no ack, sticky Error, Valid still pulses.
        no_ack   = 1;
        DataRE   = 1;
        DataAddr = 32'h300;
        n = 0;
        while (!DataValid && n < 40) begin
            tick();
            n++;
        end
        check("tmo_valid", 32'(DataValid), 32'd1);
        check("tmo_latency", n, 9);
        check("tmo_req_len", req_len, 8);
        check("tmo_error", 32'(Error), 32'd1);
        check("tmo_ddata_kept", DataReadData, 32'h5555_AAAA);
        idle_inputs();
        no_ack = 0;
        tick();
        check("tmo_memreq_low", 32'(MemReq), 32'd0);
        FetchReq  = 1;
        FetchAddr = 32'h4C;
        rd_val    = 32'h99;
        n = 0;
        while (!FetchValid && n < 40) begin
            tick();
            n++;
        end
        check("post_tmo_fvalid", 32'(FetchValid), 32'd1);
        check("post_tmo_fdata", FetchData, 32'h99);
        check("error_sticky", 32'(Error), 32'd1);
        idle_inputs();
        tick();

        // Asynchronous reset in the middle of a data access.
        no_ack   = 1;
        DataRE   = 1;
        DataAddr = 32'h400;
        tick();
        tick();
        tick();
        check("pre_rst_memreq", 32'(MemReq), 32'd1);
        #1 Reset = 1;
        #1;
        check("async_memreq", 32'(MemReq), 32'd0);
        check("async_dvalid", 32'(DataValid), 32'd0);
        check("async_error", 32'(Error), 32'd0);
        idle_inputs();
        no_ack = 0;
        tick();
        Reset = 0;
        tick();
        check("no_lost_valid", 32'(DataValid), 32'd0);
        FetchReq  = 1;
        FetchAddr = 32'h60;
        rd_val    = 32'hCAFE_0001;
        mem_wait  = 0;
        n = 0;
        while (!FetchValid && n < 40) begin
            tick();
            n++;
        end
        check("rst_after_fvalid", 32'(FetchValid), 32'd1);
        check("rst_after_latency", n, 2);
        check("rst_after_fdata", FetchData, 32'hCAFE_0001);
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
